sdram_write: RTL and testbench
==============================

Name: sdram_write

Overview:
SDRAM write-path engine, the write-side counterpart of the read engine; shares the top-level arbiter, command encoding and refresh interlock.
- Drains the write FIFO in fixed 4-beat bursts to bank 0, walking column then row addresses.
- Releases the command bus to the arbiter on refresh request or when the FIFO runs short.

Parameters:
ACT_NUM, 3, cycles spent in ACT state (tRCD); ACT issued at count 0
PRE_NUM, 3, cycles after PRE command before state exit (tRP)
TWR, 2, NOP cycles between last write beat and PRE (tWR)
BURST_LEN, 4, beats per WRITE command (fixed; mode register BL=4)
ROW_BITS, 13, row address width
COL_BITS, 10, column address width
USEDW_W, 10, width of FIFO fill count

Ports:
sclk  in  1  system clock
s_rst_n  in  1  async active-low reset
wr_en  in  1  arbiter grant; sampled only in REQ
wr_req  out  1  bus request, =1 exactly while state==REQ (combinational)
flag_wr_end  out  1  one-cycle registered pulse: bus released
ref_req  in  1  refresh pending from refresh engine
wr_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}; NOP 0111, ACT 0011, WR 0100, PRE 0010
wr_addr  out  13  SDRAM A[12:0]
bank_addr  out  2  constant 2'b00
wr_data  out  16  SDRAM DQ write data
wr_dq_oe  out  1  DQ output enable, high on data beats
wfifo_rd_en  out  1  FIFO read strobe
wfifo_rd_data  in  16  FIFO data, valid the cycle after wfifo_rd_en (registered FIFO output)
wfifo_usedw  in  USEDW_W  FIFO fill count

Behaviour:
- Reset: state IDLE; wr_cmd=NOP, wr_addr=0, wr_dq_oe=0, flag_wr_end=0; row/col counters 0. Async reset mid-operation forces all of these immediately; no PRE issued.
- wr_flag = (wfifo_usedw >= BURST_LEN).
- One-hot states:
  - IDLE: wr_flag -> REQ.
  - REQ: wr_en -> ACT; else hold REQ. ref_req is ignored here; the arbiter resolves priority.
  - ACT: act_cnt 0..ACT_NUM. At ACT_NUM -> WR.
  - WR: burst_cnt 0..3, wraps. On burst_cnt==3:
    - PRE if ref_req, or row end, or !wr_flag (sampled value that cycle);
    - otherwise next burst starts at once (gapless back-to-back WRITEs).
  - PRE: pre_cnt 0..TWR+PRE_NUM. At TWR+PRE_NUM:
    - ->IDLE if ref_req or !wr_flag; flag_wr_end=1 for the following cycle.
    - else ->ACT (bus kept).
- Commands are registered, one cycle after the state/counter condition:
  - ACT with wr_addr=row_addr when act_cnt==0.
  - WR with wr_addr={3'b000,col_addr} when burst_cnt==0.
  - PRE with wr_addr=13'h0400 (A10=1) when pre_cnt==TWR.
  - NOP with wr_addr=0 otherwise.
- Data path:
  - wfifo_rd_en=(state==WR), combinational.
  - wr_dq_oe = registered wfifo_rd_en, so beat 0 aligns with the WR command cycle.
  - wr_data = wr_dq_oe ? wfifo_rd_data : 16'h0.
  - Exactly 4 FIFO reads per WRITE command; a started burst always completes, even if ref_req rises mid-burst.
- Addressing:
  - col_addr={col_cnt[COL_BITS-3:0], 2'b00}; col_cnt increments at each burst end.
  - Row end = burst_cnt==3 with col_cnt all ones (col 1020). At row end, col_cnt->0 and row_addr+1; row_addr wraps 8191->0.
  - Counters persist across bus releases, so the next session continues the stream.
- No simultaneous grant/PRE conflict possible: the grant is only honoured in REQ.

Optional Feature:
SDRAM_WR_DQM_EN
- Defined: adds output wr_dqm[1:0]. It is a registered 2'b00 on beats (wr_dq_oe=1) and 2'b11 otherwise; reset 2'b11.
- Undefined: no port; DQM is tied low at the top.

Test Plan:
- usedw=4, wr_en 2 cycles after wr_req -> ACT row0, 3 NOP, WR col0 with D0..D3 on 4 consecutive cycles (oe=1), 2 NOP, PRE 0x0400, 3 NOP, flag_wr_end pulse, IDLE.
- usedw=16 held -> single ACT, WR at cols 0,4,8,12 every 4 cycles without gaps, 16 FIFO reads, one PRE.
- ref_req raised at burst_cnt==1 with usedw=64 -> all 4 beats written, PRE, flag_wr_end, IDLE, wr_req next cycle.
- Continuous data across row end -> last WR col 1020 row0, PRE, then ACT row1, WR col0, without flag_wr_end.
- s_rst_n low during beat 2 -> wr_cmd=NOP, wfifo_rd_en=0, wr_dq_oe=0 immediately; after release IDLE, counters 0.
- SDRAM_WR_DQM_EN defined, scenario 1 -> wr_dqm=00 on the 4 beats, 11 elsewhere; undefined build has no wr_dqm port.

Source files
------------

// File: rtl/sdram_write_if.sv
// SDRAM write-engine bus bundle: arbiter handshake, SDRAM command/address/data, write-FIFO port.
// Optional SDRAM_WR_DQM_EN adds the wr_dqm byte-mask signal.
interface sdram_write_if #(
    parameter int unsigned ROW_BITS = 13,
    parameter int unsigned USEDW_W  = 10
);
    logic               wr_en;
    logic               wr_req;
    logic               flag_wr_end;
    logic               ref_req;
    logic [3:0]         wr_cmd;
    logic [12:0]        wr_addr;
    logic [1:0]         bank_addr;
    logic [15:0]        wr_data;
    logic               wr_dq_oe;
    logic               wfifo_rd_en;
    logic [15:0]        wfifo_rd_data;
    logic [USEDW_W-1:0] wfifo_usedw;
`ifdef SDRAM_WR_DQM_EN
    logic [1:0]         wr_dqm;

    modport master (
        output wr_en, ref_req, wfifo_rd_data, wfifo_usedw,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, bank_addr, wr_data, wr_dq_oe, wfifo_rd_en, wr_dqm
    );
    modport slave (
        input  wr_en, ref_req, wfifo_rd_data, wfifo_usedw,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, bank_addr, wr_data, wr_dq_oe, wfifo_rd_en, wr_dqm
    );
`else
    modport master (
        output wr_en, ref_req, wfifo_rd_data, wfifo_usedw,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, bank_addr, wr_data, wr_dq_oe, wfifo_rd_en
    );
    modport slave (
        input  wr_en, ref_req, wfifo_rd_data, wfifo_usedw,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, bank_addr, wr_data, wr_dq_oe, wfifo_rd_en
    );
`endif
endinterface

// File: rtl/sdram_write.sv
// SDRAM write-path engine: drains the write FIFO in 4-beat bursts to bank 0,
// walking column then row, and hands the bus back on refresh or FIFO shortage.
// Optional feature macro: SDRAM_WR_DQM_EN (registered wr_dqm output).
module sdram_write #(
    parameter int unsigned ACT_NUM   = 3,
    parameter int unsigned PRE_NUM   = 3,
    parameter int unsigned TWR       = 2,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ROW_BITS  = 13,
    parameter int unsigned COL_BITS  = 10,
    parameter int unsigned USEDW_W   = 10
) (
    input  logic         sclk,
    input  logic         s_rst_n,
    sdram_write_if.slave bus
);
    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_ACT  = 4'b0011;
    localparam logic [3:0]  CMD_WR   = 4'b0100;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam int unsigned PRE_LAST = TWR + PRE_NUM;
    localparam int unsigned ACT_W    = $clog2(ACT_NUM + 1);
    localparam int unsigned PRE_W    = $clog2(PRE_LAST + 1);
    localparam int unsigned CCNT_W   = COL_BITS - 2;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_REQ  = 5'b00010,
        S_ACT  = 5'b00100,
        S_WR   = 5'b01000,
        S_PRE  = 5'b10000
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ACT_W-1:0]    r_act_cnt;
    logic [1:0]          r_burst_cnt;
    logic [PRE_W-1:0]    r_pre_cnt;
    logic [CCNT_W-1:0]   r_col_cnt;
    logic [ROW_BITS-1:0] r_row_addr;
    logic [3:0]          r_cmd;
    logic [12:0]         r_addr;
    logic                r_dq_oe;
    logic                r_flag_end;
    logic                w_wr_flag;
    logic                w_act_last;
    logic                w_burst_last;
    logic                w_pre_last;
    logic                w_row_end;
    logic                w_in_wr;
    logic [COL_BITS-1:0] w_col_addr;

    assign w_wr_flag    = (bus.wfifo_usedw >= USEDW_W'(BURST_LEN));
    assign w_in_wr      = (r_state == S_WR);
    assign w_act_last   = (r_act_cnt == ACT_W'(ACT_NUM));
    assign w_burst_last = w_in_wr && (r_burst_cnt == 2'd3);
    assign w_pre_last   = (r_pre_cnt == PRE_W'(PRE_LAST));
    assign w_row_end    = w_burst_last && (&r_col_cnt);
    assign w_col_addr   = {r_col_cnt, 2'b00};

    assign bus.wr_req      = (r_state == S_REQ);
    assign bus.wfifo_rd_en = w_in_wr;
    assign bus.wr_cmd      = r_cmd;
    assign bus.wr_addr     = r_addr;
    assign bus.bank_addr   = 2'b00;
    assign bus.wr_dq_oe    = r_dq_oe;
    assign bus.wr_data     = r_dq_oe ? bus.wfifo_rd_data : '0;
    assign bus.flag_wr_end = r_flag_end;

    // State register
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode; a burst always runs to beat 3 before PRE is considered
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_wr_flag) w_next = S_REQ;
            S_REQ:  if (bus.wr_en) w_next = S_ACT;
            S_ACT:  if (w_act_last) w_next = S_WR;
            S_WR:   if (w_burst_last && (bus.ref_req || w_row_end || !w_wr_flag)) w_next = S_PRE;
            S_PRE:  if (w_pre_last) w_next = (bus.ref_req || !w_wr_flag) ? S_IDLE : S_ACT;
            default: w_next = S_IDLE;
        endcase
    end

    // Per-state timing counters, cleared outside their own state
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_act_cnt   <= '0;
            r_burst_cnt <= '0;
            r_pre_cnt   <= '0;
        end else begin
            r_act_cnt   <= (r_state == S_ACT && !w_act_last) ? r_act_cnt + 1'b1 : '0;
            r_burst_cnt <= w_in_wr ? r_burst_cnt + 2'd1 : 2'd0;
            r_pre_cnt   <= (r_state == S_PRE && !w_pre_last) ? r_pre_cnt + 1'b1 : '0;
        end
    end

    // Column/row walk; persists across bus releases so the stream resumes in place
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_col_cnt  <= '0;
            r_row_addr <= '0;
        end else if (w_burst_last) begin
            r_col_cnt <= r_col_cnt + 1'b1;
            if (w_row_end) r_row_addr <= r_row_addr + 1'b1;
        end
    end

    // Registered command/address, one cycle behind the state/counter condition
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
        end else if (r_state == S_ACT && r_act_cnt == '0) begin
            r_cmd  <= CMD_ACT;
            r_addr <= 13'(r_row_addr);
        end else if (w_in_wr && r_burst_cnt == 2'd0) begin
            r_cmd  <= CMD_WR;
            r_addr <= 13'(w_col_addr);
        end else if (r_state == S_PRE && r_pre_cnt == PRE_W'(TWR)) begin
            r_cmd  <= CMD_PRE;
            r_addr <= 13'h0400;
        end else begin
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
        end
    end

    // DQ enable tracks FIFO reads one cycle later, matching the FIFO output register
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) r_dq_oe <= 1'b0;
        else          r_dq_oe <= w_in_wr;
    end

    // Bus-release pulse, raised for the first IDLE cycle after PRE
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) r_flag_end <= 1'b0;
        else          r_flag_end <= (r_state == S_PRE) && w_pre_last && (w_next == S_IDLE);
    end

`ifdef SDRAM_WR_DQM_EN
    logic [1:0] r_dqm;

    // Byte mask open only on data beats
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) r_dqm <= '1;
        else          r_dqm <= w_in_wr ? 2'b00 : 2'b11;
    end

    assign bus.wr_dqm = r_dqm;
`endif
endmodule

// File: tb/tb_sdram_write.sv
// Directed self-checking bench for sdram_write with a simple registered-output FIFO model.
module tb_sdram_write;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WRC = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    sdram_write_if #(.ROW_BITS(13), .USEDW_W(10)) bus ();

    sdram_write #(
        .ACT_NUM(3), .PRE_NUM(3), .TWR(2), .BURST_LEN(4),
        .ROW_BITS(13), .COL_BITS(10), .USEDW_W(10)
    ) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // FIFO model: word k reads as A000+k, data registered one cycle after the strobe
    int unsigned rd_count = 0;
    int unsigned wr_total = 0;
    logic [15:0] fifo_dout = 16'h0;
    always @(posedge sclk) begin
        if (bus.wfifo_rd_en) begin
            fifo_dout <= 16'hA000 + 16'(rd_count);
            rd_count  <= rd_count + 1;
        end
    end
    assign bus.wfifo_rd_data = fifo_dout;
    assign bus.wfifo_usedw   = (wr_total <= rd_count) ? 10'd0 :
                               ((wr_total - rd_count) > 1023) ? 10'd1023 : 10'(wr_total - rd_count);

    // Bus monitor
    logic [12:0] act_q[$];
    logic [12:0] wr_q[$];
    int unsigned wrcyc_q[$];
    logic [15:0] beat_q[$];
    int unsigned pre_n = 0;
    int unsigned flag_n = 0;
    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (bus.wr_cmd == ACT) act_q.push_back(bus.wr_addr);
            if (bus.wr_cmd == WRC) begin
                wr_q.push_back(bus.wr_addr);
                wrcyc_q.push_back(cyc);
            end
            if (bus.wr_cmd == PRE) pre_n <= pre_n + 1;
            if (bus.flag_wr_end)   flag_n <= flag_n + 1;
            if (bus.wr_dq_oe)      beat_q.push_back(bus.wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.wr_en   = 1'b0;
        bus.ref_req = 1'b0;
        s_rst_n     = 1'b0;
        wr_total    = rd_count;
        repeat (3) @(negedge sclk);
        wr_total    = rd_count;
        s_rst_n     = 1'b1;
        @(negedge sclk);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge sclk);
            if (bus.wr_req) break;
        end
        chk(tag, bus.wr_req, 1'b1);
    endtask

    task automatic grant();
        bus.wr_en = 1'b1;
        @(negedge sclk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge sclk);
            if (bus.flag_wr_end) break;
        end
        chk(tag, bus.flag_wr_end, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base, a0, w0, p0, f0, b0;
        logic [3:0]  e_cmd;
        logic [12:0] e_addr;
        logic [15:0] e_data;
        logic        e_oe, e_rd, e_flag;

        bus.wr_en   = 1'b0;
        bus.ref_req = 1'b0;

        // Reset state
        @(negedge sclk);
        chk("rst_cmd",   bus.wr_cmd, NOP);
        chk("rst_addr",  bus.wr_addr, 13'h0);
        chk("rst_oe",    bus.wr_dq_oe, 1'b0);
        chk("rst_flag",  bus.flag_wr_end, 1'b0);
        chk("rst_req",   bus.wr_req, 1'b0);
        chk("rst_rden",  bus.wfifo_rd_en, 1'b0);
        chk("rst_bank",  bus.bank_addr, 2'b00);
`ifdef SDRAM_WR_DQM_EN
        chk("rst_dqm",   bus.wr_dqm, 2'b11);
`endif
        do_reset();

        // S1: single burst, grant two cycles after request
        base     = rd_count;
        wr_total = rd_count + 4;
        @(negedge sclk);
        chk("s1_req0", bus.wr_req, 1'b1);
        @(negedge sclk);
        chk("s1_req1", bus.wr_req, 1'b1);
        @(negedge sclk);
        chk("s1_req2", bus.wr_req, 1'b1);
        bus.wr_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge sclk);
            bus.wr_en = 1'b0;
            e_cmd  = (c == 1) ? ACT : (c == 5) ? WRC : (c == 11) ? PRE : NOP;
            e_addr = (c == 11) ? 13'h0400 : 13'h0;
            e_rd   = (c >= 4 && c <= 7);
            e_oe   = (c >= 5 && c <= 8);
            e_flag = (c == 14);
            e_data = 16'h0;
            if (e_oe) e_data = 16'hA000 + 16'(base + c - 5);
            chk($sformatf("s1_cmd_c%0d", c),  bus.wr_cmd, e_cmd);
            chk($sformatf("s1_addr_c%0d", c), bus.wr_addr, e_addr);
            chk($sformatf("s1_rden_c%0d", c), bus.wfifo_rd_en, e_rd);
            chk($sformatf("s1_oe_c%0d", c),   bus.wr_dq_oe, e_oe);
            chk($sformatf("s1_data_c%0d", c), bus.wr_data, e_data);
            chk($sformatf("s1_flag_c%0d", c), bus.flag_wr_end, e_flag);
            chk($sformatf("s1_req_c%0d", c),  bus.wr_req, 1'b0);
`ifdef SDRAM_WR_DQM_EN
            chk($sformatf("s1_dqm_c%0d", c),  bus.wr_dqm, e_oe ? 2'b00 : 2'b11);
`endif
        end
        chk("s1_reads", rd_count - base, 4);

        // S2: 16 words -> four gapless bursts under one ACT, one PRE
        do_reset();
        base = rd_count; a0 = act_q.size(); w0 = wr_q.size(); p0 = pre_n; f0 = flag_n; b0 = beat_q.size();
        wr_total = rd_count + 16;
        wait_req("s2_req");
        grant();
        wait_flag("s2_flag", 200);
        @(negedge sclk);
        chk("s2_acts",  act_q.size() - a0, 1);
        chk("s2_act_row", act_q[a0], 13'h0);
        chk("s2_wrs",   wr_q.size() - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s2_col%0d", i), wr_q[w0 + i], 13'(4 * i));
            if (i > 0) chk($sformatf("s2_gap%0d", i), wrcyc_q[w0 + i] - wrcyc_q[w0 + i - 1], 4);
        end
        chk("s2_pres",  pre_n - p0, 1);
        chk("s2_flags", flag_n - f0, 1);
        chk("s2_reads", rd_count - base, 16);
        chk("s2_beats", beat_q.size() - b0, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("s2_beat%0d", i), beat_q[b0 + i], 16'hA000 + 16'(base + i));

        // S3: refresh request mid-burst; burst completes, bus released, re-request follows
        base = rd_count; w0 = wr_q.size(); p0 = pre_n; b0 = beat_q.size();
        wr_total = rd_count + 64;
        wait_req("s3_req");
        grant();
        for (int i = 0; i < 20; i++) begin
            if (bus.wfifo_rd_en) break;
            @(negedge sclk);
        end
        chk("s3_rden", bus.wfifo_rd_en, 1'b1);
        @(negedge sclk);
        bus.ref_req = 1'b1;
        wait_flag("s3_flag", 50);
        chk("s3_req_at_flag", bus.wr_req, 1'b0);
        chk("s3_reads", rd_count - base, 4);
        @(negedge sclk);
        chk("s3_req_after", bus.wr_req, 1'b1);
        bus.ref_req = 1'b0;
        chk("s3_wrs",   wr_q.size() - w0, 1);
        chk("s3_col",   wr_q[w0], 13'd16);
        chk("s3_pres",  pre_n - p0, 1);
        chk("s3_beats", beat_q.size() - b0, 4);

        // S4: continuous stream across the row end
        do_reset();
        a0 = act_q.size(); w0 = wr_q.size(); p0 = pre_n; f0 = flag_n;
        wr_total = rd_count + 100000;
        wait_req("s4_req");
        grant();
        for (int i = 0; i < 1500; i++) begin
            @(negedge sclk);
            if (wr_q.size() - w0 >= 257) break;
        end
        @(negedge sclk);
        chk("s4_wrs_seen", (wr_q.size() - w0 >= 257), 1'b1);
        chk("s4_last_col", wr_q[w0 + 255], 13'h3FC);
        chk("s4_gapless",  wrcyc_q[w0 + 255] - wrcyc_q[w0], 1020);
        chk("s4_new_col",  wr_q[w0 + 256], 13'h0);
        chk("s4_acts",     act_q.size() - a0, 2);
        chk("s4_act_row0", act_q[a0], 13'h0);
        chk("s4_act_row1", act_q[a0 + 1], 13'h1);
        chk("s4_pres",     pre_n - p0, 1);
        chk("s4_no_flag",  flag_n - f0, 0);

        // S5: asynchronous reset during beat 2
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            if (bus.wr_cmd == WRC) break;
        end
        chk("s5_wr_seen", bus.wr_cmd, WRC);
        repeat (2) @(negedge sclk);
        chk("s5_beat2_oe", bus.wr_dq_oe, 1'b1);
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("s5_cmd",  bus.wr_cmd, NOP);
        chk("s5_addr", bus.wr_addr, 13'h0);
        chk("s5_rden", bus.wfifo_rd_en, 1'b0);
        chk("s5_oe",   bus.wr_dq_oe, 1'b0);
        chk("s5_data", bus.wr_data, 16'h0);
        chk("s5_flag", bus.flag_wr_end, 1'b0);
        wr_total = rd_count;
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        repeat (2) @(negedge sclk);
        chk("s5_idle_req", bus.wr_req, 1'b0);
        chk("s5_idle_cmd", bus.wr_cmd, NOP);
        a0 = act_q.size(); w0 = wr_q.size();
        wr_total = rd_count + 4;
        wait_req("s5_req");
        grant();
        wait_flag("s5_flag", 50);
        chk("s5_row0", act_q[a0], 13'h0);
        chk("s5_col0", wr_q[w0], 13'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
